div8su_seq: RTL and testbench

- Sequential signed-dividend by unsigned-divisor integer divider; the inverse operation of the team's signed×unsigned array multipliers.
- Takes an 8-bit signed dividend and a 4-bit unsigned divisor.
- Returns a truncating signed quotient and a remainder that carries the dividend's sign.
- Restoring radix-2 datapath, one quotient bit per cycle; valid/ready handshake on both sides. Sits next to the multiplier family for inverse-checking and for scaling blocks.

---
 rtl/div8su_seq.sv | 209 ++++++++++++++++++++
 tb/tb_div8su_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div8su_seq.sv
// ---------------------------------------------------------------------------
// div8su_seq
// Sequential signed-dividend / unsigned-divisor integer divider.
//   - DW-bit two's complement dividend, VW-bit unsigned divisor
//   - truncating signed quotient, remainder carries the dividend's sign
//   - restoring radix-2 datapath, one quotient bit per cycle, MSB first
//   - valid/ready handshake on operand and result sides, no skid buffer
//
// Optional feature macro: DIV8SU_SELFCHECK_EN
//   When defined, an extra CHK state rebuilds q*u+r and compares it with
//   the original dividend, flagging chk_err on mismatch (latency DW+3).
//   When undefined, chk_err is tied low and latency is DW+2.
// ---------------------------------------------------------------------------
module div8su_seq #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] s,
   input  logic        [VW-1:0] u,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] q,
   output logic signed [VW:0]   r,
   output logic                 dz,
   output logic                 chk_err
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
`ifdef DIV8SU_SELFCHECK_EN
      ST_CHK,
`endif
      ST_DONE
   } state_t;

   state_t                r_state;
   logic                  r_inReady;
   logic                  r_outValid;
   logic                  r_signS;
   logic [DW-1:0]         r_work;
   logic [VW-1:0]         r_div;
   logic [VW:0]           r_rem;
   logic [CW-1:0]         r_cnt;
   logic signed [DW-1:0]  r_q;
   logic signed [VW:0]    r_r;
   logic                  r_dz;

   logic [DW-1:0]         w_absS;
   logic [VW:0]           w_remShift;
   logic                  w_subOk;
   logic [VW:0]           w_remNext;
   logic signed [DW-1:0]  w_satQ;

`ifdef DIV8SU_SELFCHECK_EN
   logic signed [DW-1:0]     r_sOrig;
   logic                     r_chkErr;
   logic signed [DW+VW-1:0]  w_prod;
   logic signed [DW+VW-1:0]  w_recon;
   logic signed [DW+VW-1:0]  w_sExt;
`endif

   // Magnitude of the incoming dividend; -2^(DW-1) maps to 2^(DW-1), which
   // still fits in DW unsigned bits, so no special case is needed.
   always_comb begin
      w_absS = s[DW-1] ? $unsigned(-s) : $unsigned(s);
   end

   // One restoring step: bring in the next dividend bit (held in the MSB of
   // r_work) and subtract the divisor when it fits. Because the remainder is
   // always below u, its top bit is zero before the shift and VW+1 bits
   // always hold the shifted value.
   always_comb begin
      w_remShift = {r_rem[VW-1:0], r_work[DW-1]};
      w_subOk    = (w_remShift >= {1'b0, r_div});
      w_remNext  = w_subOk ? (w_remShift - {1'b0, r_div}) : w_remShift;
   end

   // Saturated quotient reported on divide-by-zero: most negative value for a
   // negative dividend, most positive value otherwise.
   always_comb begin
      w_satQ = s[DW-1] ? $signed({1'b1, {(DW-1){1'b0}}})
                       : $signed({1'b0, {(DW-1){1'b1}}});
   end

`ifdef DIV8SU_SELFCHECK_EN
   // Rebuild the dividend from the registered result: a signed quotient
   // times a zero-extended divisor plus the sign-extended remainder, all in
   // DW+VW bits so the product can never wrap for legal results.
   always_comb begin
      w_prod  = $signed({{VW{r_q[DW-1]}}, r_q}) * $signed({{DW{1'b0}}, r_div});
      w_recon = w_prod + $signed({{(DW-1){r_r[VW]}}, r_r});
      w_sExt  = $signed({{VW{r_sOrig[DW-1]}}, r_sOrig});
   end
`endif

   // Main controller: operand capture, iteration, sign fix-up and result
   // hold. r_work starts as the dividend magnitude and, as bits shift out of
   // its top, quotient bits shift into its bottom, so after DW steps it holds
   // the quotient magnitude. out_valid is raised one cycle after entering
   // DONE, which sets the overall latency to DW+2 (or 1 cycle for a zero
   // divisor).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_signS    <= 1'b0;
         r_work     <= '0;
         r_div      <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
         r_q        <= '0;
         r_r        <= '0;
         r_dz       <= 1'b0;
`ifdef DIV8SU_SELFCHECK_EN
         r_sOrig    <= '0;
         r_chkErr   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_signS   <= s[DW-1];
                  r_work    <= w_absS;
                  r_div     <= u;
                  r_inReady <= 1'b0;
`ifdef DIV8SU_SELFCHECK_EN
                  r_sOrig   <= s;
                  r_chkErr  <= 1'b0;
`endif
                  if (u == '0) begin
                     r_q     <= w_satQ;
                     r_r     <= '0;
                     r_dz    <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_rem   <= '0;
                     r_cnt   <= CW'(DW - 1);
                     r_state <= ST_CALC;
                  end
               end
            end

            ST_CALC: begin
               r_rem  <= w_remNext;
               r_work <= {r_work[DW-2:0], w_subOk};
               r_cnt  <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state <= ST_FIX;
               end
            end

            ST_FIX: begin
               r_q  <= r_signS ? $signed(-r_work) : $signed(r_work);
               r_r  <= r_signS ? $signed(-r_rem)  : $signed(r_rem);
               r_dz <= 1'b0;
`ifdef DIV8SU_SELFCHECK_EN
               r_state <= ST_CHK;
`else
               r_state <= ST_DONE;
`endif
            end

`ifdef DIV8SU_SELFCHECK_EN
            ST_CHK: begin
               r_chkErr <= (w_recon != w_sExt);
               r_state  <= ST_DONE;
            end
`endif

            ST_DONE: begin
               if (!r_outValid) begin
                  r_outValid <= 1'b1;
               end else if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end

            default: begin
               r_outValid <= 1'b0;
               r_inReady  <= 1'b1;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign q         = r_q;
   assign r         = r_r;
   assign dz        = r_dz;
`ifdef DIV8SU_SELFCHECK_EN
   assign chk_err   = r_chkErr;
`else
   assign chk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_div8su_seq.sv
// ---------------------------------------------------------------------------
// tb_div8su_seq
// Scoreboard bench for div8su_seq. The driver pushes the expected result of
// every accepted operation (computed with plain integer division) into a
// queue; a monitor pops and compares whenever the DUT presents a result.
// Honours DIV8SU_SELFCHECK_EN for the expected latency and adds an
// exhaustive sweep when it is defined.
// ---------------------------------------------------------------------------
module tb_div8su_seq;

`ifdef DIV8SU_SELFCHECK_EN
   localparam int LAT = 11;
`else
   localparam int LAT = 10;
`endif

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] s;
   logic [3:0]        u;
   logic              out_valid;
   logic              out_ready;
   logic signed [7:0] q;
   logic signed [4:0] r;
   logic              dz;
   logic              chk_err;

   typedef struct {
      logic signed [7:0] q;
      logic signed [4:0] r;
      logic              dz;
      int                acceptCycle;
      int                lat;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   bit   haveCur;
   int   readyMode;
   int   cycle;
   int   checks;
   int   failures;

   div8su_seq #(.DW(8), .VW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .s         (s),
      .u         (u),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .r         (r),
      .dz        (dz),
      .chk_err   (chk_err)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to measure latency
   always @(posedge clk) cycle <= cycle + 1;

   // Hard stop in case something stalls beyond every bounded wait
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog actual=still running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=timeout required=event", name);
   endtask

   // Drive one operation; when track is set, push its expected result
   task automatic applyStimulus(input logic signed [7:0] sv, input logic [3:0] uv, input bit track);
      int   n;
      int   si;
      int   ui;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         timeoutFail("inReadyWait");
         return;
      end
      s        = sv;
      u        = uv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (track) begin
         si = sv;
         ui = uv;
         if (ui == 0) begin
            e.q  = (si < 0) ? 8'h80 : 8'h7f;
            e.r  = '0;
            e.dz = 1'b1;
            e.lat = 1;
         end else begin
            e.q  = 8'(si / ui);
            e.r  = 5'(si % ui);
            e.dz = 1'b0;
            e.lat = LAT;
         end
         e.acceptCycle = cycle;
         sb.push_back(e);
      end
   endtask

   // Wait until every pushed result has been consumed
   task automatic waitDrain();
      int n;
      n = 0;
      while (!(sb.size() == 0 && !haveCur && in_ready) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!(sb.size() == 0 && !haveCur && in_ready)) timeoutFail("drain");
   endtask

   // Monitor: on first sight of a result pop the scoreboard and compare,
   // then keep checking that the result stays put until it is accepted.
   // It also owns out_ready, deciding it on each falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         haveCur   = 1'b0;
         out_ready = 1'b0;
      end else begin
         if (out_valid) begin
            if (!haveCur) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpectedResult actual=q %0d r %0d required=no result pending", q, r);
               end else begin
                  cur     = sb.pop_front();
                  haveCur = 1'b1;
                  checkOutput("latency", cycle - cur.acceptCycle, cur.lat);
                  checkOutput("q", q, cur.q);
                  checkOutput("r", r, cur.r);
                  checkOutput("dz", dz, cur.dz);
                  checkOutput("chkErr", chk_err, 0);
               end
            end else begin
               checkOutput("qHold", q, cur.q);
               checkOutput("rHold", r, cur.r);
               checkOutput("dzHold", dz, cur.dz);
            end
            case (readyMode)
               1:       out_ready = 1'b0;
               2:       out_ready = 1'b1;
               default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (out_ready) haveCur = 1'b0;
         end else begin
            out_ready = (readyMode == 1) ? 1'b0 : ($urandom_range(0, 1) == 1);
         end
      end
   end

   // Directed operand table from the intended use cases and corner values
   logic signed [7:0] dirS [10] = '{-8'sd120, 8'sd105, -8'sd7, 8'sd7, -8'sd1,
                                    -8'sd128, 8'sd127, -8'sd128, 8'sd13, -8'sd5};
   logic [3:0]        dirU [10] = '{4'd15, 4'd15, 4'd2, 4'd2, 4'd15,
                                    4'd1, 4'd1, 4'd15, 4'd0, 4'd0};

   // Main sequence
   initial begin
      int n;
      cycle     = 0;
      checks    = 0;
      failures  = 0;
      haveCur   = 1'b0;
      readyMode = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      s         = '0;
      u         = '0;
      out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstInReady", in_ready, 1);
      checkOutput("rstOutValid", out_valid, 0);
      checkOutput("rstQ", q, 0);
      checkOutput("rstR", r, 0);
      checkOutput("rstDz", dz, 0);
      checkOutput("rstChkErr", chk_err, 0);
      rst_n = 1'b1;

      // Directed cases
      for (int i = 0; i < 10; i++) applyStimulus(dirS[i], dirU[i], 1'b1);
      waitDrain();

      // Backpressure: result held while out_ready stays low, new operands ignored
      readyMode = 1;
      applyStimulus(-8'sd100, 4'd9, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) timeoutFail("bpOutValid");
      #1;
      s        = 8'sd50;
      u        = 4'd3;
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checkOutput("bpInReady", in_ready, 0);
         checkOutput("bpOutValid", out_valid, 1);
      end
      #1;
      in_valid  = 1'b0;
      readyMode = 2;
      @(negedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("bpOutValidDrop", out_valid, 0);
      checkOutput("bpInReadyBack", in_ready, 1);
      readyMode = 0;
      waitDrain();

      // Reset during the fourth CALC cycle discards the operation
      applyStimulus(8'sd100, 4'd7, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midRstInReady", in_ready, 1);
      checkOutput("midRstOutValid", out_valid, 0);
      checkOutput("midRstQ", q, 0);
      checkOutput("midRstR", r, 0);
      checkOutput("midRstDz", dz, 0);
      checkOutput("midRstChkErr", chk_err, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         checkOutput("noValidAfterRst", out_valid, 0);
      end

      // Randomized operations
      for (int i = 0; i < 300; i++) begin
         applyStimulus(8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
      end
      waitDrain();

`ifdef DIV8SU_SELFCHECK_EN
      // Full sweep of every dividend against every non-zero divisor
      for (int si = -128; si < 128; si++) begin
         for (int ui = 1; ui < 16; ui++) begin
            applyStimulus(8'(si), 4'(ui), 1'b1);
         end
      end
      waitDrain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
